// File: rtl/wb_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_fetch_pkg
// Description : Shared types and constants for the Wishbone random-word
//               fetcher: FSM state encoding, bus widths and a helper that
//               sizes the FIFO level counter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_fetch_pkg;

    localparam int         DATA_W  = 32;
    localparam logic [3:0] SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    // A level counter must represent 0..DEPTH inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_random_fetcher_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rand_sync_fifo
// Description : DEPTH x 32 synchronous FIFO holding fetched random words.
//               Head word is presented combinationally from storage.
// Ports       : clk, rst        - clock / synchronous active-high reset
//               push, push_data - write request and data
//               pop             - read request (ignored when empty)
//               head_data       - word at the head of the queue
//               level           - registered occupancy 0..DEPTH
//               empty, full     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module rand_sync_fifo
    import wb_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    full
);

    localparam int               PTR_W        = $clog2(DEPTH);
    localparam int               LVL_W        = level_width(DEPTH);
    localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_full_level);
    assign level     = r_level;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle, so the freed slot is reused without overflow.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never exposed as valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/wb_random_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : wb_random_fetcher
// Description : Wishbone initiator that keeps a local FIFO of random words
//               topped up with single 32-bit reads from a fixed address, with
//               bounded wait, back-off and a saturating abort counter.
// Ports       : clk, rst          - clock / synchronous active-high reset
//               enable            - allow new bus fetches
//               wbm_*             - Wishbone initiator interface
//               rnd_valid_o/data  - stream head (valid = FIFO not empty)
//               rnd_ready_i       - consumer pop
//               level_o           - FIFO occupancy
//               timeout_cnt_o     - saturating count of aborted cycles
// Revision    : 1.0 - initial release
// ============================================================================
module wb_random_fetcher
    import wb_fetch_pkg::*;
#(
    parameter logic [31:0] TARGET_ADR = 32'h3000_0000,
    parameter int          DEPTH      = 4,
    parameter int          TIMEOUT    = 16,
    parameter int          BACKOFF    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    output logic [3:0]             wbm_sel_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i,
    output logic                   rnd_valid_o,
    output logic [31:0]            rnd_data_o,
    input  logic                   rnd_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [7:0]             timeout_cnt_o
);

    localparam int              WAIT_W         = $clog2(TIMEOUT);
    localparam int              BO_W           = $clog2(BACKOFF) + 1;
    localparam logic [WAIT_W-1:0] c_wait_last    = WAIT_W'(TIMEOUT - 1);
    localparam logic [BO_W-1:0]   c_backoff_last = BO_W'(BACKOFF - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_cyc;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [BO_W-1:0]   r_backoff_cnt;
    logic [7:0]        r_timeout_cnt;

    logic              w_wait_done;
    logic              w_backoff_done;
    logic              w_push;
    logic              w_abort;
    logic              w_cyc_next;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_cyc;
    assign wbm_we_o      = 1'b0;
    assign wbm_adr_o     = TARGET_ADR;
    assign wbm_dat_o     = '0;
    assign wbm_sel_o     = SEL_ALL;
    assign rnd_valid_o   = ~w_fifo_empty;
    assign timeout_cnt_o = r_timeout_cnt;

    assign w_wait_done    = (r_wait_cnt == c_wait_last);
    assign w_backoff_done = (r_backoff_cnt == c_backoff_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; ack takes priority over the timeout check so a reply
    // on the last permitted wait cycle is still accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && !w_fifo_full) w_next_state = ST_BUS;
            end
            ST_BUS: begin
                if (wbm_ack_i)        w_next_state = ST_IDLE;
                else if (w_wait_done) w_next_state = ST_BACKOFF;
            end
            ST_BACKOFF: begin
                if (w_backoff_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode; acks seen outside BUS never push.
    always_comb begin
        w_push     = (r_state == ST_BUS) && wbm_ack_i;
        w_abort    = (r_state == ST_BUS) && !wbm_ack_i && w_wait_done;
        w_cyc_next = (w_next_state == ST_BUS);
    end

    // Bus strobe and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc         <= 1'b0;
            r_wait_cnt    <= '0;
            r_backoff_cnt <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_cyc <= w_cyc_next;

            if (r_state == ST_BUS && !wbm_ack_i && !w_wait_done)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else
                r_wait_cnt <= '0;

            if (r_state == ST_BACKOFF && !w_backoff_done)
                r_backoff_cnt <= r_backoff_cnt + BO_W'(1);
            else
                r_backoff_cnt <= '0;

            if (w_abort && r_timeout_cnt != 8'hFF)
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
        end
    end

    rand_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (wbm_dat_i),
        .pop       (rnd_ready_i),
        .head_data (rnd_data_o),
        .level     (level_o),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_random_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_random_fetcher
// Description : Directed self-checking bench for wb_random_fetcher with a
//               registered-ack responder model (configurable delay / mute).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_random_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        rnd_valid_o;
    logic [31:0] rnd_data_o;
    logic        rnd_ready_i;
    logic [2:0]  level_o;
    logic [7:0]  timeout_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    // Responder model
    int resp_n     = 0;
    int resp_wait  = 0;
    int resp_delay = 0;
    bit resp_never = 1'b0;

    always #5 clk = ~clk;

    wb_random_fetcher dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_dat_i     (wbm_dat_i),
        .wbm_ack_i     (wbm_ack_i),
        .rnd_valid_o   (rnd_valid_o),
        .rnd_data_o    (rnd_data_o),
        .rnd_ready_i   (rnd_ready_i),
        .level_o       (level_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    // Acks one cycle after stb has been seen for resp_delay+1 cycles, and
    // drops ack the cycle after asserting it.
    always @(posedge clk) begin
        if (wbm_stb_o && !wbm_ack_i && !resp_never && resp_wait == resp_delay) begin
            wbm_ack_i <= 1'b1;
            wbm_dat_i <= 32'h1000_0000 + 32'(resp_n);
            resp_n    <= resp_n + 1;
            resp_wait <= 0;
        end else begin
            wbm_ack_i <= 1'b0;
            if (wbm_stb_o && !wbm_ack_i) resp_wait <= resp_wait + 1;
            else                         resp_wait <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, last, min_sp, h, l, hi_cnt;
        logic prev;

        rst = 1'b1; enable = 1'b0; rnd_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state and constant outputs
        check("rst_cyc",     32'(wbm_cyc_o),     32'd0);
        check("rst_stb",     32'(wbm_stb_o),     32'd0);
        check("rst_level",   32'(level_o),       32'd0);
        check("rst_valid",   32'(rnd_valid_o),   32'd0);
        check("rst_timeout", 32'(timeout_cnt_o), 32'd0);
        check("const_adr",   wbm_adr_o,          32'h3000_0000);
        check("const_sel",   32'(wbm_sel_o),     32'hF);
        check("const_we",    32'(wbm_we_o),      32'd0);

        // Fill: four fetches at 3-cycle spacing, then silence while full
        rst = 1'b0; enable = 1'b1;
        rises = 0; last = -100; min_sp = 1000; prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wbm_stb_o && !prev) begin
                if (rises > 0 && (c - last) < min_sp) min_sp = c - last;
                last = c;
                rises++;
            end
            prev = wbm_stb_o;
        end
        check("fill_rises",  32'(rises),       32'd4);
        check("fill_spacing",32'(min_sp),      32'd3);
        check("fill_level",  32'(level_o),     32'd4);
        check("fill_valid",  32'(rnd_valid_o), 32'd1);
        check("fill_head",   rnd_data_o,       32'h1000_0000);
        hi_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wbm_stb_o) hi_cnt++;
        end
        check("full_no_stb", 32'(hi_cnt), 32'd0);

        // Pop sequence with refetch and simultaneous push/pop
        rnd_ready_i = 1'b1;
        @(negedge clk);                                   // popped word 0
        rnd_ready_i = 1'b0;
        check("pop1_data",  rnd_data_o,     32'h1000_0001);
        check("pop1_level", 32'(level_o),   32'd3);
        check("pop1_stb",   32'(wbm_stb_o), 32'd0);
        @(negedge clk);
        check("refetch_stb", 32'(wbm_stb_o), 32'd1);
        @(negedge clk);                                   // ack cycle
        rnd_ready_i = 1'b1;
        @(negedge clk);                                   // push + pop
        check("pp_level", 32'(level_o), 32'd3);
        check("pp_data",  rnd_data_o,   32'h1000_0002);
        @(negedge clk);
        check("pop3_data",  rnd_data_o,     32'h1000_0003);
        check("pop3_level", 32'(level_o),   32'd2);
        check("pop3_stb",   32'(wbm_stb_o), 32'd1);
        @(negedge clk);
        check("pop4_data",  rnd_data_o,   32'h1000_0004);
        check("pop4_level", 32'(level_o), 32'd1);
        @(negedge clk);
        check("pp2_data",  rnd_data_o,   32'h1000_0005);
        check("pp2_level", 32'(level_o), 32'd1);
        rnd_ready_i = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("dis_stb", 32'(wbm_stb_o), 32'd0);
        rnd_ready_i = 1'b1;
        @(negedge clk);
        rnd_ready_i = 1'b0;
        check("drain_valid", 32'(rnd_valid_o), 32'd0);
        check("drain_level", 32'(level_o),     32'd0);
        // Pop on empty is ignored
        rnd_ready_i = 1'b1;
        @(negedge clk);
        rnd_ready_i = 1'b0;
        check("empty_pop_level", 32'(level_o), 32'd0);

        // Silent responder: 16-cycle strobe, 9 low cycles (8 back-off + idle)
        resp_never = 1'b1; enable = 1'b1;
        l = 0;
        while (!wbm_stb_o && l < 40) begin l++; @(negedge clk); end
        check("to_start", 32'(wbm_stb_o), 32'd1);
        h = 0;
        while (wbm_stb_o && h < 40) begin h++; @(negedge clk); end
        check("to_stb_len", 32'(h),             32'd16);
        check("to_cnt1",    32'(timeout_cnt_o), 32'd1);
        l = 0;
        while (!wbm_stb_o && l < 40) begin l++; @(negedge clk); end
        check("to_gap", 32'(l), 32'd9);

        // Retry acked on the last permitted wait cycle
        resp_never = 1'b0; resp_delay = 14;
        h = 0;
        while (wbm_stb_o && h < 40) begin h++; @(negedge clk); end
        enable = 1'b0;
        check("late_ack_len",   32'(h),             32'd16);
        check("late_ack_level", 32'(level_o),       32'd1);
        check("late_ack_data",  rnd_data_o,         32'h1000_0006);
        check("late_ack_to",    32'(timeout_cnt_o), 32'd1);
        rnd_ready_i = 1'b1;
        @(negedge clk);
        rnd_ready_i = 1'b0;

        // Many aborts: counter saturates
        resp_delay = 0; resp_never = 1'b1; enable = 1'b1;
        repeat (7600) @(negedge clk);
        enable = 1'b0;
        check("to_saturate", 32'(timeout_cnt_o), 32'd255);
        l = 0;
        while (wbm_stb_o && l < 40) begin l++; @(negedge clk); end
        repeat (12) @(negedge clk);
        resp_never = 1'b0;
        check("to_no_push", 32'(level_o), 32'd0);

        // enable dropped during BUS; delayed ack still completes
        resp_delay = 3; enable = 1'b1;
        l = 0;
        while (!wbm_stb_o && l < 40) begin l++; @(negedge clk); end
        h = 0;
        while (wbm_stb_o && h < 40) begin
            h++;
            if (h == 2) enable = 1'b0;
            @(negedge clk);
        end
        check("en_drop_len",   32'(h),         32'd5);
        check("en_drop_level", 32'(level_o),   32'd1);
        check("en_drop_data",  rnd_data_o,     32'h1000_0007);
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wbm_stb_o) hi_cnt++;
        end
        check("en_drop_idle", 32'(hi_cnt), 32'd0);

        // Reset during BUS with an ack about to arrive
        resp_delay = 0; enable = 1'b1;
        l = 0;
        while (!wbm_stb_o && l < 40) begin l++; @(negedge clk); end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_stb",   32'(wbm_stb_o),   32'd0);
        check("mid_rst_level", 32'(level_o),     32'd0);
        check("mid_rst_valid", 32'(rnd_valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_nopush", 32'(level_o), 32'd0);
        enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_random_fetcher.md
Name: wb_random_fetcher

Overview:
Wishbone initiator that keeps a small local FIFO of random words topped up by issuing single 32-bit read cycles to the pseudorandom responder at a fixed address. LED effect engines pop words through a valid/ready stream port, so they never stall on the bus. A bounded-wait timeout with back-off and a saturating error counter protect the design against a missing or hung responder.

Parameters:
TARGET_ADR, 32'h3000_0000, byte address driven on every read cycle
DEPTH, 4, FIFO depth in 32-bit words; power of two, 2..16
TIMEOUT, 16, cycles stb may stay asserted without ack before abort; ≥2
BACKOFF, 8, idle cycles after a timeout before retrying; ≥1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = allow new bus fetches
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable; always 0
wbm_adr_o  out  32  Wishbone address; always TARGET_ADR
wbm_dat_o  out  32  Wishbone write data; always 0
wbm_sel_o  out  4  Wishbone byte enables; always 4'hF
wbm_dat_i  in  32  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge
rnd_valid_o  out  1  FIFO not empty
rnd_data_o  out  32  FIFO head word; valid only while rnd_valid_o = 1
rnd_ready_i  in  1  consumer pop
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
timeout_cnt_o  out  8  saturating count of aborted cycles

Behaviour:
- Reset is synchronous and active-high (rst); one clock, clk. When rst = 1 at a rising edge:
  - state = IDLE; cyc/stb = 0; FIFO empty; level_o = 0; rnd_valid_o = 0; timeout_cnt_o = 0; wait and back-off counters = 0.
  - rst asserted mid-transaction drops cyc/stb on the next edge and discards any in-flight read.
- cyc and stb are registered and always equal; we/adr/dat/sel are constants.
- FSM states: IDLE, BUS, BACKOFF.
  - IDLE -> BUS when enable = 1 and level_o < DEPTH; cyc/stb rise on that edge.
  - BUS: cyc/stb held high. On the edge where ack = 1:
    - wbm_dat_i is pushed into the FIFO.
    - cyc/stb drop; next state is IDLE.
    - Ack is honoured whenever it arrives, including at wait count TIMEOUT-1.
  - BUS: wait counter increments each cycle without ack. When it reaches TIMEOUT-1 with no ack:
    - cyc/stb drop; next state is BACKOFF.
    - timeout_cnt_o increments, saturating at 255.
  - BACKOFF: count BACKOFF cycles, then go to IDLE.
- stb is low for at least one cycle between transactions, because IDLE always sits between consecutive BUS states. This matches the registered-ack responder: ack rises one cycle after stb and falls the cycle after.
- Best-case throughput is one word per 3 cycles: stb, ack, idle.
- An ack arriving in IDLE or BACKOFF is ignored; no push occurs.
- Only one transaction is ever outstanding, and it is issued only when the FIFO is not full. A push therefore never overflows, even if no pop happens.
- enable falling during BUS does not abort the cycle; it completes (ack or timeout) and the FSM then stays in IDLE.
- FIFO:
  - Pop happens when rnd_valid_o & rnd_ready_i.
  - rnd_data_o is the head word; it is not required to be zero when rnd_valid_o = 0.
  - Simultaneous push and pop leaves the level unchanged and is legal even when the FIFO is full.
  - A pop on empty is ignored.
  - Pointers wrap modulo DEPTH.
  - Push and pop take effect at the edge, and level_o is registered.
- Latency: stb rising edge to rnd_valid_o is 2 cycles with an immediate ack (ack at cycle 1, data visible at cycle 2).

Decomposition:
- Package wb_fetch_pkg:
  - FSM state enum (IDLE, BUS, BACKOFF).
  - Wishbone constants: SEL_ALL = 4'hF, data width 32.
  - Helper function for the level width.
- One natural sub-module: rand_sync_fifo (DEPTH x 32, synchronous reset, push/pop/level/empty/full).
- The FSM and counters stay in the top module.

Test Plan:
- Reset then enable = 1, responder model returns 0x1000_0000+n with a 1-cycle registered ack:
  - FIFO fills to 4 with words 0x1000_0000..0x1000_0003, then no stb while full.
  - stb high-to-high spacing is ≥3 cycles.
- FIFO full, then consumer pops one word per cycle:
  - Words pop in order.
  - Refetch starts the cycle after the level first drops below 4.
  - A push and a pop in the same cycle keep level_o constant.
- Responder never acks:
  - stb stays high for exactly 16 cycles, then drops.
  - 8 cycles of BACKOFF follow; timeout_cnt_o = 1; retry then follows.
  - After 300 such failures, timeout_cnt_o = 255.
- Ack arrives at wait count 15 (the last permitted cycle): word is pushed, timeout_cnt_o unchanged.
- enable dropped one cycle after stb rises and ack is delayed 3 cycles:
  - The transaction completes and the word is pushed.
  - No further stb appears while enable = 0.
- rst asserted during BUS with a pending ack: next edge has cyc/stb = 0, level_o = 0, and the late ack causes no push.
